pattern_reflector: RTL and testbench

Far-end responder for the rotating-pattern traffic generator/checker. Sits on the far side of the link under test. It:
- receives test packets on an AXI-Stream slave port and checks each word against the rotating-seed pattern;
- buffers packets store-and-forward in a packet FIFO;
- reflects each buffered packet back on an AXI-Stream master port so the generator's checker can close the loop.

It exposes per-packet good/error/drop/transmit counters.

---
 rtl/pattern_reflector.sv | 246 ++++++++++++++++++++++++
 tb/tb_pattern_reflector.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_reflector.sv
// pattern_reflector: far-end responder for rotating-pattern traffic.
// Checks ingress packets, buffers them store-and-forward, reflects them.
//
// Ports:
//   axi_aclk, axi_aresetn  clock, async active-low reset
//   s_axis_*               ingress stream (tdata/tstrb/tuser/tvalid/tlast/tready)
//   m_axis_*               egress stream, same fields
//   count_reset            synchronous clear of all packet counters
//   rx_good_count, rx_err_count, rx_drop_count, tx_count  32-bit counters
module pattern_reflector #(
    parameter int                      C_DATA_WIDTH    = 64,
    parameter int                      C_TUSER_WIDTH   = 128,
    parameter int                      C_PKT_SIZE      = 16,
    parameter int                      C_MAX_PKT_WORDS = 32,
    parameter int                      C_FIFO_DEPTH    = 64,
    parameter logic [C_DATA_WIDTH-1:0] C_SEED          = 64'hCAFEBEEFCAFEBEEF,
    parameter bit                      C_DROP_BAD      = 1'b1
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    input  logic                      count_reset,
    output logic [31:0]               rx_good_count,
    output logic [31:0]               rx_err_count,
    output logic [31:0]               rx_drop_count,
    output logic [31:0]               tx_count
);

    localparam int SW = C_DATA_WIDTH / 8;
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = C_DATA_WIDTH + SW + C_TUSER_WIDTH + 1;
    localparam int CW = $clog2(C_MAX_PKT_WORDS + 1) + 1;

    typedef enum logic [1:0] {
        ING_IDLE,
        ING_STORE,
        ING_DROP
    } ing_state_t;

    typedef enum logic {
        NOSPACE,
        OVERSIZE
    } drop_reason_t;

    // Rotate-right of the seed by k mod width, via a doubled copy.
    function automatic logic [C_DATA_WIDTH-1:0] f_ror(input logic [CW-1:0] k);
        logic [2*C_DATA_WIDTH-1:0] w_dbl;
        w_dbl = {C_SEED, C_SEED} >> (32'(k) % C_DATA_WIDTH);
        return w_dbl[C_DATA_WIDTH-1:0];
    endfunction

    logic [EW-1:0]             r_mem [C_FIFO_DEPTH];
    ing_state_t                r_state;
    drop_reason_t              r_reason;
    logic                      r_s_ready;
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_commit_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_word_cnt;
    logic                      r_ok;
    logic [31:0]               r_good_cnt;
    logic [31:0]               r_err_cnt;
    logic [31:0]               r_drop_cnt;
    logic [31:0]               r_tx_cnt;
    logic [C_DATA_WIDTH-1:0]   r_m_tdata;
    logic [SW-1:0]             r_m_tstrb;
    logic [C_TUSER_WIDTH-1:0]  r_m_tuser;
    logic                      r_m_tvalid;
    logic                      r_m_tlast;

    logic [PW-1:0]             w_used;
    logic                      w_space;
    logic                      w_beat;
    logic                      w_idle;
    logic                      w_match;
    logic                      w_at_max;
    logic                      w_wr_en;
    logic                      w_eop;
    logic [CW-1:0]             w_cnt_final;
    logic                      w_ok_final;
    logic                      w_good;
    logic                      w_m_hs;
    logic                      w_load;

    assign w_used  = r_commit_ptr - r_rd_ptr;
    // Admission only looks at committed data; the speculative region is
    // bounded by C_MAX_PKT_WORDS so it never overruns unread entries.
    assign w_space = (C_FIFO_DEPTH - int'(w_used)) >= C_MAX_PKT_WORDS;

    assign w_beat      = s_axis_tvalid && r_s_ready;
    assign w_idle      = r_state == ING_IDLE;
    assign w_match     = s_axis_tdata == f_ror(w_idle ? '0 : r_word_cnt);
    assign w_at_max    = r_word_cnt == CW'(C_MAX_PKT_WORDS);
    assign w_wr_en     = w_beat &&
                         ((w_idle && w_space) ||
                          (r_state == ING_STORE && !w_at_max));
    assign w_eop       = w_wr_en && s_axis_tlast;
    assign w_cnt_final = w_idle ? CW'(1) : r_word_cnt + 1'b1;
    assign w_ok_final  = w_match && (w_idle || r_ok);
    assign w_good      = w_ok_final && (w_cnt_final == CW'(C_PKT_SIZE));

    assign w_m_hs = r_m_tvalid && m_axis_tready;
    assign w_load = (r_rd_ptr != r_commit_ptr) &&
                    (!r_m_tvalid || m_axis_tready);

    always_ff @(posedge axi_aclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tdata, s_axis_tstrb,
                                        s_axis_tuser, s_axis_tlast};
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state      <= ING_IDLE;
            r_reason     <= NOSPACE;
            r_s_ready    <= 1'b0;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_word_cnt   <= '0;
            r_ok         <= 1'b0;
            r_good_cnt   <= '0;
            r_err_cnt    <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_s_ready <= 1'b1;
            if (w_wr_en) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_word_cnt <= w_cnt_final;
                r_ok       <= w_ok_final;
            end
            // Packet end: commit or roll back the speculative words.
            if (w_eop) begin
                if (w_good || !C_DROP_BAD) begin
                    r_commit_ptr <= r_wr_ptr + 1'b1;
                end else begin
                    r_wr_ptr <= r_commit_ptr;
                end
                if (w_good) begin
                    r_good_cnt <= r_good_cnt + 32'd1;
                end else begin
                    r_err_cnt <= r_err_cnt + 32'd1;
                end
            end
            if (w_beat) begin
                unique case (r_state)
                    ING_IDLE: begin
                        if (!w_space) begin
                            // A one-beat packet that is refused ends here.
                            if (s_axis_tlast) begin
                                r_drop_cnt <= r_drop_cnt + 32'd1;
                            end else begin
                                r_state  <= ING_DROP;
                                r_reason <= NOSPACE;
                            end
                        end else if (!s_axis_tlast) begin
                            r_state <= ING_STORE;
                        end
                    end
                    ING_STORE: begin
                        if (w_at_max) begin
                            if (s_axis_tlast) begin
                                r_err_cnt <= r_err_cnt + 32'd1;
                                r_wr_ptr  <= r_commit_ptr;
                                r_state   <= ING_IDLE;
                            end else begin
                                r_state  <= ING_DROP;
                                r_reason <= OVERSIZE;
                            end
                        end else if (s_axis_tlast) begin
                            r_state <= ING_IDLE;
                        end
                    end
                    ING_DROP: begin
                        if (s_axis_tlast) begin
                            r_state <= ING_IDLE;
                            if (r_reason == OVERSIZE) begin
                                r_err_cnt <= r_err_cnt + 32'd1;
                                r_wr_ptr  <= r_commit_ptr;
                            end else begin
                                r_drop_cnt <= r_drop_cnt + 32'd1;
                            end
                        end
                    end
                    default: r_state <= ING_IDLE;
                endcase
            end
            if (count_reset) begin
                r_good_cnt <= '0;
                r_err_cnt  <= '0;
                r_drop_cnt <= '0;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_rd_ptr   <= '0;
            r_m_tdata  <= '0;
            r_m_tstrb  <= '0;
            r_m_tuser  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_tx_cnt   <= '0;
        end else begin
            if (w_load) begin
                {r_m_tdata, r_m_tstrb, r_m_tuser, r_m_tlast} <=
                    r_mem[r_rd_ptr[AW-1:0]];
                r_m_tvalid <= 1'b1;
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end else if (w_m_hs) begin
                r_m_tvalid <= 1'b0;
            end
            if (w_m_hs && r_m_tlast) begin
                r_tx_cnt <= r_tx_cnt + 32'd1;
            end
            if (count_reset) begin
                r_tx_cnt <= '0;
            end
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tstrb  = r_m_tstrb;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign rx_good_count = r_good_cnt;
    assign rx_err_count  = r_err_cnt;
    assign rx_drop_count = r_drop_cnt;
    assign tx_count      = r_tx_cnt;

endmodule

// File: tb/tb_pattern_reflector.sv
// tb_pattern_reflector: directed bench for pattern_reflector.
// Instance 0 drops bad packets, instance 1 reflects them.
module tb_pattern_reflector;

    localparam logic [63:0] SEED = 64'hCAFEBEEFCAFEBEEF;

    typedef struct packed {
        logic         last;
        logic [7:0]   strb;
        logic [127:0] user;
        logic [63:0]  data;
    } beat_t;

    typedef struct {
        int n;
        int flip;
        int good;
        int err;
        int words0;
        int words1;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [63:0]  s_tdata = '0;
    logic [7:0]   s_tstrb = '0;
    logic [127:0] s_tuser = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         m_tready = 1'b0;
    logic         count_reset = 1'b0;

    logic [1:0]         s_tready;
    logic [1:0][63:0]   m_tdata;
    logic [1:0][7:0]    m_tstrb;
    logic [1:0][127:0]  m_tuser;
    logic [1:0]         m_tvalid;
    logic [1:0]         m_tlast;
    logic [1:0][31:0]   good_c, err_c, drop_c, tx_c;
    logic [1:0][31:0]   g0, e0, d0, t0;

    beat_t q0[$];
    beat_t q1[$];

    int n_tests = 0;
    int n_fail = 0;

    pattern_reflector #(.C_DROP_BAD(1'b1)) u_dut_drop (
        .axi_aclk(clk), .axi_aresetn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tstrb(m_tstrb[0]),
        .m_axis_tuser(m_tuser[0]), .m_axis_tvalid(m_tvalid[0]),
        .m_axis_tlast(m_tlast[0]), .m_axis_tready(m_tready),
        .count_reset(count_reset),
        .rx_good_count(good_c[0]), .rx_err_count(err_c[0]),
        .rx_drop_count(drop_c[0]), .tx_count(tx_c[0])
    );

    pattern_reflector #(.C_DROP_BAD(1'b0)) u_dut_keep (
        .axi_aclk(clk), .axi_aresetn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tstrb(m_tstrb[1]),
        .m_axis_tuser(m_tuser[1]), .m_axis_tvalid(m_tvalid[1]),
        .m_axis_tlast(m_tlast[1]), .m_axis_tready(m_tready),
        .count_reset(count_reset),
        .rx_good_count(good_c[1]), .rx_err_count(err_c[1]),
        .rx_drop_count(drop_c[1]), .tx_count(tx_c[1])
    );

    // Record every egress handshake of each instance.
    always @(negedge clk) begin
        if (rstn && m_tready) begin
            if (m_tvalid[0]) begin
                q0.push_back({m_tlast[0], m_tstrb[0], m_tuser[0], m_tdata[0]});
            end
            if (m_tvalid[1]) begin
                q1.push_back({m_tlast[1], m_tstrb[1], m_tuser[1], m_tdata[1]});
            end
        end
    end

    function automatic logic [63:0] pat(input int k);
        int r;
        r = k % 64;
        if (r == 0) return SEED;
        return (SEED >> r) | (SEED << (64 - r));
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_pkt(input int n, input int flip, input bit cr_last);
        for (int k = 0; k < n; k++) begin
            s_tdata = pat(k) ^ ((k == flip) ? 64'd1 : 64'd0);
            s_tuser = 128'(k);
            s_tstrb = 8'hFF;
            s_tvalid = 1'b1;
            s_tlast = (k == n - 1);
            count_reset = cr_last && (k == n - 1);
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        count_reset = 1'b0;
    endtask

    task automatic check_pkt(input int d, input int n, input int flip,
                             input string tag);
        beat_t e;
        int sz;
        sz = (d == 1) ? q1.size() : q0.size();
        chk($sformatf("%s dut%0d words", tag, d), 128'(sz >= n ? n : sz),
            128'(n));
        for (int k = 0; k < n && k < sz; k++) begin
            e = (d == 1) ? q1.pop_front() : q0.pop_front();
            chk($sformatf("%s dut%0d w%0d data", tag, d, k), 128'(e.data),
                128'(pat(k) ^ ((k == flip) ? 64'd1 : 64'd0)));
            chk($sformatf("%s dut%0d w%0d last", tag, d, k), 128'(e.last),
                128'(k == n - 1));
            chk($sformatf("%s dut%0d w%0d user", tag, d, k), e.user, 128'(k));
            chk($sformatf("%s dut%0d w%0d strb", tag, d, k), 128'(e.strb),
                128'(8'hFF));
        end
    endtask

    task automatic snap();
        g0 = good_c;
        e0 = err_c;
        d0 = drop_c;
        t0 = tx_c;
    endtask

    task automatic chk_delta(input string tag, input int d, input int dg,
                             input int de, input int dd, input int dt);
        chk($sformatf("%s dut%0d good", tag, d), 128'(good_c[d] - g0[d]), 128'(dg));
        chk($sformatf("%s dut%0d err", tag, d), 128'(err_c[d] - e0[d]), 128'(de));
        chk($sformatf("%s dut%0d drop", tag, d), 128'(drop_c[d] - d0[d]), 128'(dd));
        chk($sformatf("%s dut%0d tx", tag, d), 128'(tx_c[d] - t0[d]), 128'(dt));
    endtask

    task automatic chk_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s dut%0d tvalid", tag, d), 128'(m_tvalid[d]), 128'(0));
            chk($sformatf("%s dut%0d tdata", tag, d), 128'(m_tdata[d]), 128'(0));
            chk($sformatf("%s dut%0d tready", tag, d), 128'(s_tready[d]), 128'(0));
            chk($sformatf("%s dut%0d cnt", tag, d),
                128'({good_c[d], err_c[d], drop_c[d], tx_c[d]}), 128'(0));
        end
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{n: 16, flip: -1, good: 1, err: 0, words0: 16, words1: 16};
        vt[1] = '{n: 16, flip: 5,  good: 0, err: 1, words0: 0,  words1: 16};
        vt[2] = '{n: 11, flip: -1, good: 0, err: 1, words0: 0,  words1: 11};
        vt[3] = '{n: 40, flip: -1, good: 0, err: 1, words0: 0,  words1: 0};
        vt[4] = '{n: 16, flip: -1, good: 1, err: 0, words0: 16, words1: 16};
        vt[5] = '{n: 16, flip: 15, good: 0, err: 1, words0: 0,  words1: 16};
        vt[6] = '{n: 1,  flip: -1, good: 0, err: 1, words0: 0,  words1: 1};
        vt[7] = '{n: 32, flip: -1, good: 0, err: 1, words0: 0,  words1: 32};
        vt[8] = '{n: 33, flip: -1, good: 0, err: 1, words0: 0,  words1: 0};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("tready after reset", 128'(s_tready), 128'(2'b11));

        // Latency: tlast at edge N, tvalid visible only after edge N+1.
        m_tready = 1'b1;
        send_pkt(16, -1, 1'b0);
        @(negedge clk);
        chk("latency tvalid N", 128'(m_tvalid[0]), 128'(0));
        @(negedge clk);
        chk("latency tvalid N+1", 128'(m_tvalid[0]), 128'(1));
        repeat (30) @(posedge clk);
        @(negedge clk);
        check_pkt(0, 16, -1, "first");
        check_pkt(1, 16, -1, "first");
        chk("first good", 128'(good_c[0]), 128'(1));
        chk("first tx", 128'(tx_c[0]), 128'(1));

        foreach (vt[i]) begin
            snap();
            send_pkt(vt[i].n, vt[i].flip, 1'b0);
            repeat (50) @(posedge clk);
            @(negedge clk);
            chk_delta($sformatf("vec%0d", i), 0, vt[i].good, vt[i].err, 0,
                      vt[i].words0 > 0 ? 1 : 0);
            chk_delta($sformatf("vec%0d", i), 1, vt[i].good, vt[i].err, 0,
                      vt[i].words1 > 0 ? 1 : 0);
            check_pkt(0, vt[i].words0, vt[i].flip, $sformatf("vec%0d", i));
            check_pkt(1, vt[i].words1, vt[i].flip, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d leftover", i),
                128'(q0.size() + q1.size()), 128'(0));
        end

        // Backpressure: the egress register pulls word 0 of packet 1 out
        // of the FIFO, so at packet 3's SOP free = 64 - 31 = 33 >= 32.
        // Packets 1-3 are stored, packets 4-5 are refused.
        m_tready = 1'b0;
        snap();
        for (int p = 0; p < 5; p++) send_pkt(16, -1, 1'b0);
        repeat (3) @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d valid", c), 128'(m_tvalid[0]), 128'(1));
            chk($sformatf("stall%0d data", c), 128'(m_tdata[0]), 128'(SEED));
            chk($sformatf("stall%0d last", c), 128'(m_tlast[0]), 128'(0));
        end
        chk_delta("bp", 0, 3, 0, 2, 0);
        chk_delta("bp", 1, 3, 0, 2, 0);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        repeat (48) @(negedge clk);
        #1;
        chk("bp back-to-back", 128'(q0.size()), 128'(48));
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            check_pkt(0, 16, -1, $sformatf("bp%0d", p));
            check_pkt(1, 16, -1, $sformatf("bp%0d", p));
        end
        chk("bp extra", 128'(q0.size() + q1.size()), 128'(0));
        chk_delta("bp end", 0, 3, 0, 2, 3);

        // count_reset coinciding with a good tlast wins over the increment.
        send_pkt(16, -1, 1'b1);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("creset dut%0d cnt", d),
                128'({good_c[d], err_c[d], drop_c[d], tx_c[d]}), 128'(0));
        end
        repeat (30) @(posedge clk);
        @(negedge clk);
        check_pkt(0, 16, -1, "creset");
        chk("creset tx", 128'(tx_c[0]), 128'(1));
        chk("creset good", 128'(good_c[0]), 128'(0));

        // Asynchronous reset in the middle of egress.
        send_pkt(16, -1, 1'b0);
        begin
            int waited;
            waited = 0;
            while (q0.size() < 7 && waited < 100) begin
                @(negedge clk);
                #1;
                waited++;
            end
            chk("areset wait word 7", 128'(q0.size() >= 7), 128'(1));
        end
        @(posedge clk);
        #1;
        chk("areset word7 data", 128'(m_tdata[0]), 128'(pat(7)));
        rstn = 1'b0;
        #1;
        chk_reset_state("areset");
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("areset fifo empty", 128'(m_tvalid), 128'(0));
        q0.delete();
        q1.delete();
        send_pkt(16, -1, 1'b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check_pkt(0, 16, -1, "post-reset");
        check_pkt(1, 16, -1, "post-reset");
        chk("post-reset good", 128'(good_c[0]), 128'(1));
        chk("post-reset tx", 128'(tx_c[1]), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
